// File: rtl/enc8to3_seq.sv
// enc8to3_seq: sequential 8-to-3 encoder (inverse of a 3-to-8 decoder).
// A request vector is accepted through a valid/ready handshake and latched.
// The binary index of every set bit is then emitted one per output
// handshake, and the final index is flagged with out_last.
// An all-zero vector is absorbed with a one-cycle zero_seen pulse.
// Build option: define ENC8TO3_MSB_FIRST_EN to emit indices highest-first.
// By default, indices are emitted lowest-first.
module enc8to3_seq #(
  parameter int NUM_IN = 8,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_IN-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [IDX_W-1:0]  out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              zero_seen,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Index of the set bit to serve next: lowest by default, highest when the
  // MSB-first option is built in. Returns 0 for an empty vector.
  function automatic logic [IDX_W-1:0] pick_idx(input logic [NUM_IN-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
`ifdef ENC8TO3_MSB_FIRST_EN
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < NUM_IN; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
`else
    // Descending scan: the last hit is the lowest set bit.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
`endif
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_single(input logic [NUM_IN-1:0] v);
    return (v != '0) && ((v & (v - NUM_IN'(1))) == '0);
  endfunction

  state_t              r_state;
  logic [NUM_IN-1:0]   r_pend;
  logic [IDX_W-1:0]    r_out;
  logic                r_out_valid;
  logic                r_out_last;
  logic                r_zero_seen;

  state_t              w_state_nxt;
  logic [NUM_IN-1:0]   w_pend_nxt;
  logic [IDX_W-1:0]    w_out_nxt;
  logic                w_out_valid_nxt;
  logic                w_out_last_nxt;
  logic                w_zero_seen_nxt;

  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [NUM_IN-1:0]   w_pend_left;

  assign w_in_ready  = (r_state == ST_IDLE) & en & ~rst;
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  // Pending bits once the index currently on out has been handed over.
  assign w_pend_left = r_pend & ~(NUM_IN'(1) << r_out);

  // Next-state and next-output decode for the IDLE/EMIT machine.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned;
    // a missing default here would infer a latch.
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend;
    w_out_nxt       = r_out;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_zero_seen_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          if (in != '0) begin
            // Load the vector and present its first index right away so
            // out_valid rises the cycle after acceptance.
            w_state_nxt     = ST_EMIT;
            w_pend_nxt      = in;
            w_out_nxt       = pick_idx(in);
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = is_single(in);
          end else begin
            w_zero_seen_nxt = 1'b1;
          end
        end
      end

      ST_EMIT: begin
        // Without a handshake all outputs hold, which keeps out stable
        // under backpressure.
        if (w_out_fire) begin
          w_pend_nxt = w_pend_left;
          if (r_out_last) begin
            w_state_nxt     = ST_IDLE;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
          end else begin
            w_out_nxt      = pick_idx(w_pend_left);
            w_out_last_nxt = is_single(w_pend_left);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset beats any handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_zero_seen <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_zero_seen <= w_zero_seen_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign zero_seen = r_zero_seen;
  assign busy      = (r_state == ST_EMIT);

endmodule

// File: tb/tb_enc8to3_seq.sv
// tb_enc8to3_seq: checks enc8to3_seq with a table of directed vectors,
// hand-written backpressure/enable/reset sequences, and random vectors.
// The random vectors are compared against a set-bit list model.
// If ENC8TO3_MSB_FIRST_EN is defined, the expected order is reversed.
module tb_enc8to3_seq;

  typedef struct packed {
    logic [7:0]      vec;
    logic [3:0]      n;     // number of set bits
    logic [7:0][2:0] idx;   // set-bit indices in ascending order
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in_vec;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       zero_seen;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  enc8to3_seq #(.NUM_IN(8), .IDX_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in_vec),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .zero_seen (zero_seen),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (actual timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: list the set bits of v by plain bit scanning.
  function automatic vec_t model(input logic [7:0] v);
    vec_t r;
    r.vec = v;
    r.n   = '0;
    r.idx = '0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) begin
        r.idx[r.n[2:0]] = 3'(b);
        r.n = r.n + 4'd1;
      end
    end
    return r;
  endfunction

  // k-th expected index in emission order.
  function automatic logic [2:0] exp_at(input vec_t e, input int k);
`ifdef ENC8TO3_MSB_FIRST_EN
    return e.idx[int'(e.n) - 1 - k];
`else
    return e.idx[k];
`endif
  endfunction

  // Offer one vector, then drain its indices while checking order, out_last,
  // hold-under-stall, latency and the return to IDLE.
  task automatic run_vec(input vec_t e, input bit rnd_ready);
    int k;
    int cyc;
    bit stalled;
    logic [2:0] held;
    en        = 1'b1;
    in_vec    = e.vec;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1 check("in_ready_accept", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
    if (e.n == 0) begin
      check("zero_seen_pulse", 32'(zero_seen), 1);
      check("zero_no_valid", 32'(out_valid), 0);
      check("zero_not_busy", 32'(busy), 0);
      check("zero_in_ready", 32'(in_ready), 1);
      tick();
      check("zero_seen_end", 32'(zero_seen), 0);
      return;
    end
    check("first_latency", 32'(out_valid), 1);
    check("busy_emit", 32'(busy), 1);
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (k < int'(e.n) && cyc < 64) begin
      if (stalled) begin
        check("hold_out", 32'(out_idx), 32'(held));
        check("hold_valid", 32'(out_valid), 1);
      end
      out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_ready) begin
        check("beat_idx", 32'(out_idx), 32'(exp_at(e, k)));
        check("beat_last", 32'(out_last), 32'(k == int'(e.n) - 1));
        k++;
        stalled = 1'b0;
      end else begin
        held = out_idx;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (k != int'(e.n)) check("beat_timeout", 32'(k), 32'(e.n));
    if (!rnd_ready) check("emit_cycles", 32'(cyc), 32'(e.n));
    check("done_valid", 32'(out_valid), 0);
    check("done_busy", 32'(busy), 0);
    check("done_in_ready", 32'(in_ready), 1);
  endtask

  vec_t tbl[5];
  vec_t e;
  int   seen;

  initial begin
    tbl[0] = '{vec: 8'hA4, n: 4'd3, idx: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}};
    tbl[1] = '{vec: 8'h80, n: 4'd1, idx: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[2] = '{vec: 8'h00, n: 4'd0, idx: '0};
    tbl[3] = '{vec: 8'h01, n: 4'd1, idx: '0};
    tbl[4] = '{vec: 8'hFF, n: 4'd8, idx: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};

    // Reset state, with en and in_valid high to prove rst masks in_ready.
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_vec = 8'h5A; out_ready = 1'b1;
    tick();
    tick();
    check("rst_out", 32'(out_idx), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_zero_seen", 32'(zero_seen), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    tick();

    // Directed table with out_ready held high.
    for (int i = 0; i < 5; i++) run_vec(tbl[i], 1'b0);

    // Backpressure: first index held for three stalled cycles.
    en = 1'b1; in_vec = 8'hA4; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp_out", 32'(out_idx), 32'(exp_at(tbl[0], 0)));
      check("bp_valid", 32'(out_valid), 1);
      check("bp_busy", 32'(busy), 1);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_beat", 32'(out_idx), 32'(exp_at(tbl[0], k)));
      check("bp_last", 32'(out_last), 32'(k == 2));
      check("bp_busy_drain", 32'(busy), 1);
      tick();
    end
    out_ready = 1'b0;
    check("bp_done_valid", 32'(out_valid), 0);

    // Enable low: nothing is captured.
    en = 1'b0; in_vec = 8'h3C; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("en_low_ready", 32'(in_ready), 0);
      tick();
      check("en_low_valid", 32'(out_valid), 0);
      check("en_low_busy", 32'(busy), 0);
    end
    in_valid = 1'b0; en = 1'b1;
    tick();
    check("en_low_no_capture", 32'(out_valid), 0);

    // Reset mid-EMIT after three indices of 8'hFF.
    in_vec = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_mid_beat", 32'(out_idx), 32'(exp_at(tbl[4], k)));
      tick();
    end
    rst = 1'b1;
    #1 check("rst_mid_ready", 32'(in_ready), 0);
    tick();
    check("rst_mid_valid", 32'(out_valid), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_ready_hold", 32'(in_ready), 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("rst_no_leftover", 32'(seen), 0);
    out_ready = 1'b0;

    // Random vectors against the model, with random backpressure.
    for (int r = 0; r < 40; r++) begin
      e = model(8'($urandom));
      run_vec(e, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/enc8to3_seq.md
# enc8to3_seq

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 decoders. It accepts an 8-bit request vector through a valid/ready handshake and latches it. It then emits the 3-bit binary index of every set bit, one per accepted output beat, marking the final index with `out_last`. It sits between request-collection logic and any consumer that needs binary indices serialised, e.g. the `in` port of a downstream decoder.

## Interface
- `NUM_IN`, default 8: width of request vector; power of two, 2..256.
- `IDX_W`, default 3: index width; must equal log2(`NUM_IN`).

Ports:
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `en`  input  1  enable; gates acceptance of new vectors only.
- `in`  input  `NUM_IN`  request vector.
- `in_valid`  input  1  `in` is valid.
- `in_ready`  output  1  block can accept a vector this cycle.
- `out`  output  `IDX_W`  binary index of the current set bit.
- `out_valid`  output  1  `out` holds a valid index.
- `out_ready`  input  1  consumer accepts `out` this cycle.
- `out_last`  output  1  current index is the last one of the vector.
- `zero_seen`  output  1  one-cycle pulse: an all-zero vector was accepted.
- `busy`  output  1  state is EMIT.

## Operation
- State machine with two states, IDLE and EMIT. Internal register `pend[NUM_IN-1:0]` holds the unserved bits.
- `in_ready` = (state == IDLE) & `en` & ~`rst`. It is combinational.
- IDLE behaviour:
  - An input handshake (`in_valid & in_ready`) with `in != 0` sets `pend <= in` and moves to EMIT.
  - An input handshake with `in == 0` stays in IDLE and pulses `zero_seen` high on the next cycle.
- EMIT behaviour:
  - `out` is the index of the lowest set bit of `pend`. The `ENC8TO3_MSB_FIRST_EN` macro changes this.
  - `out_last` = 1 when `pend` has exactly one bit set.
  - An output handshake (`out_valid & out_ready`) clears the emitted bit in `pend`.
  - If `out_last` was 1 at the handshake, go to IDLE; otherwise stay in EMIT.
- `out`, `out_valid`, `out_last`, `zero_seen` and `busy` are registered.
- `out_valid` never drops without a handshake. `out`, `out_last` and `out_valid` stay stable while `out_valid & ~out_ready`.
- `en` low during EMIT does not pause emission; it only blocks the next acceptance.
- `in` and `in_valid` are ignored outside the handshake; only the captured copy is used.

## Timing
- Reset value of every output: `out`=0, `out_valid`=0, `out_last`=0, `zero_seen`=0, `busy`=0, `in_ready`=0. `pend` is cleared and the state goes to IDLE.
- Latency: vector accepted at edge N gives `out_valid`=1 with the first index in cycle N+1.
- Throughput: with `out_ready` held high, one index per cycle with no bubbles. A vector with k set bits occupies EMIT for exactly k cycles.
- The last output handshake at edge M returns the block to IDLE. `in_ready` is high in cycle M+1 if `en` is high, so the back-to-back vector gap is one cycle.
- `zero_seen` is high for exactly one cycle, the cycle after a zero-vector acceptance. `in_ready` stays high through it.
- Reset mid-EMIT: at the reset edge, the remaining bits are discarded and `out_valid` goes to 0. `in_ready` stays 0 while `rst` is high.
- Reset has priority over a simultaneous input or output handshake.
- `in_valid` asserted while busy: there is no handshake, so the producer must hold `in`.

## Configuration
- `ENC8TO3_MSB_FIRST_EN`:
  - Defined: `out` is the index of the highest set bit of `pend`, so indices are emitted in descending order.
  - Undefined (default): lowest set bit first, ascending order.
- The macro does not change `out_last` semantics or timing.

## Test plan
- Ascending order: reset, `en`=1, `in`=8'b1010_0100, `out_ready`=1.
  - Required: `out`=2, 5, 7 in three consecutive cycles starting one cycle after acceptance.
  - `out_last`=1 only with 7.
  - `in_ready` high again in the following cycle.
- Backpressure: same vector with `out_ready` low for 3 cycles, then high.
  - Required: `out`=2 with `out_valid` stays stable for 3 cycles, then 2, 5, 7 follow.
  - `busy`=1 throughout.
- Single bit and zero vector:
  - `in`=8'h80 → single beat `out`=7, `out_last`=1.
  - `in`=8'h00 → no `out_valid`, `zero_seen`=1 for one cycle, state stays IDLE.
- Enable and reset:
  - `en`=0 with `in_valid`=1 → `in_ready`=0, nothing captured.
  - `in`=8'hFF, then `rst`=1 after `out`=2 is emitted → next cycle `out_valid`=0, `busy`=0, and no indices 3..7 appear after reset.
- MSB-first build: with `ENC8TO3_MSB_FIRST_EN` defined, `in`=8'b1010_0100 → `out`=7, 5, 2, with `out_last`=1 on 2.
